// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg
//   Shared definitions for the WS2812B strip controller: pixel width,
//   default frame sizing, the frame FSM state encoding and small helpers
//   that split a packed pixel into its colour channels.
package ws2812b_pkg;

  localparam int unsigned PIXEL_W              = 24;
  localparam int unsigned NUM_LEDS_DEFAULT     = 8;
  localparam int unsigned LATCH_CYCLES_DEFAULT = 3000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_LATCH     = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Pixel layout is {red, green, blue}, 8 bits each.
  function automatic logic [7:0] px_red(input logic [PIXEL_W-1:0] px);
    return px[23:16];
  endfunction

  function automatic logic [7:0] px_green(input logic [PIXEL_W-1:0] px);
    return px[15:8];
  endfunction

  function automatic logic [7:0] px_blue(input logic [PIXEL_W-1:0] px);
    return px[7:0];
  endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// ws2812b_pixel_ram
//   DEPTH x 24 pixel buffer, one synchronous write port and one registered
//   read port. Writes/reads at addresses >= DEPTH are dropped. The read
//   register samples the array before the same-edge write lands, so a
//   simultaneous write/read of one address returns the old pixel. Only
//   the read register is reset; the array keeps its contents.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   wr_en_i/addr/data   write strobe, 8-bit address, 24-bit pixel
//   rd_en_i/addr        read strobe, 8-bit address
//   rd_data_o           registered read data (holds between reads)
module ws2812b_pixel_ram
  import ws2812b_pkg::*;
#(
  parameter int unsigned DEPTH = NUM_LEDS_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [7:0]         wr_addr_i,
  input  logic [PIXEL_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [7:0]         rd_addr_i,
  output logic [PIXEL_W-1:0] rd_data_o
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << AW;

  logic [PIXEL_W-1:0] mem_q [SLOTS];
  logic [PIXEL_W-1:0] rd_data_q;
  logic               wr_ok_s;
  logic               rd_ok_s;

  // Out-of-range addresses must never alias onto a valid slot.
  assign wr_ok_s = wr_en_i && ({1'b0, wr_addr_i} < 9'(DEPTH));
  assign rd_ok_s = rd_en_i && ({1'b0, rd_addr_i} < 9'(DEPTH));

  // Pixel array write port (not reset).
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

  // Registered read port, holds its value between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_ok_s) begin
      rd_data_q <= mem_q[rd_addr_i[AW-1:0]];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ws2812b_strip_ctrl.sv
// ws2812b_strip_ctrl
//   Frame sequencer for a WS2812B strip. Holds NUM_LEDS pixels and, on
//   i_start, hands them one by one to a downstream bit-serialiser
//   (o_send + colour, handshake via i_px_busy), then holds the line low
//   for LATCH_CYCLES cycles and pulses o_done.
// Ports:
//   clk, rst_n                 50 MHz clock, async active-low reset
//   i_wr_en/i_wr_addr/i_wr_data pixel buffer write (accepted in any state)
//   i_start                    frame request, honoured in IDLE only
//   o_busy, o_done             frame in progress / end-of-frame pulse
//   o_send, o_red/green/blue   pixel strobe and colour to downstream
//   i_px_busy                  downstream busy flag
module ws2812b_strip_ctrl
  import ws2812b_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = NUM_LEDS_DEFAULT,
  parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [7:0]         i_wr_addr,
  input  logic [PIXEL_W-1:0] i_wr_data,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_send,
  output logic [7:0]         o_red,
  output logic [7:0]         o_green,
  output logic [7:0]         o_blue,
  input  logic               i_px_busy
);

  localparam int unsigned          LATCH_W  = $clog2(LATCH_CYCLES + 1);
  localparam logic [7:0]           LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [LATCH_W-1:0]   LAT_LAST = LATCH_W'(LATCH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           idx_q, idx_d;
  logic [LATCH_W-1:0]   lat_q, lat_d;
  logic                 busy_q, done_q, send_q;
  logic                 rd_en_s;
  logic [PIXEL_W-1:0]   px_s;

  // The RAM read register doubles as the colour output register: it is
  // loaded only in LOAD, so the colour is stable during SEND and holds
  // until the next pixel.
  ws2812b_pixel_ram #(
    .DEPTH (NUM_LEDS)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (i_wr_en),
    .wr_addr_i (i_wr_addr),
    .wr_data_i (i_wr_data),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (idx_q),
    .rd_data_o (px_s)
  );

  // Next-state, pixel index and latch counter logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    rd_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          idx_d   = 8'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rd_en_s = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_px_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_px_busy) begin
          if (idx_q == LAST_IDX) begin
            lat_d   = '0;
            state_d = ST_LATCH;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_LATCH: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_DONE;
        end else begin
          lat_d   = lat_q + LATCH_W'(1);
          state_d = ST_LATCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; status outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
      send_q  <= (state_d == ST_SEND);
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_send  = send_q;
  assign o_red   = px_red(px_s);
  assign o_green = px_green(px_s);
  assign o_blue  = px_blue(px_s);

endmodule

// File: tb/tb_ws2812b_strip_ctrl.sv
// Directed bench for ws2812b_strip_ctrl: instance A with default sizing
// (8 pixels, 3000 latch cycles) and instance B with 1 pixel / 4 latch
// cycles, each driving a small downstream busy model.
module tb_ws2812b_strip_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        a_wr_en = 1'b0;
  logic [7:0]  a_wr_addr = 8'd0;
  logic [23:0] a_wr_data = 24'd0;
  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_send, a_px_busy;
  logic [7:0]  a_red, a_green, a_blue;

  ws2812b_strip_ctrl u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (a_wr_en),
    .i_wr_addr (a_wr_addr),
    .i_wr_data (a_wr_data),
    .i_start   (a_start),
    .o_busy    (a_busy),
    .o_done    (a_done),
    .o_send    (a_send),
    .o_red     (a_red),
    .o_green   (a_green),
    .o_blue    (a_blue),
    .i_px_busy (a_px_busy)
  );

  // Downstream model A: busy from the cycle after o_send, for 1200 cycles.
  int a_ds_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_ds_cnt <= 0;
    else if (a_send) a_ds_cnt <= 1200;
    else if (a_ds_cnt != 0) a_ds_cnt <= a_ds_cnt - 1;
  end
  assign a_px_busy = (a_ds_cnt != 0);

  logic [23:0] a_sends[$];
  int a_done_cnt = 0, a_fall_cyc = 0, a_done_lat = 0, a_dbl = 0;
  logic a_prev_pb = 1'b0, a_prev_send = 1'b0;
  always @(negedge clk) begin
    if (a_send) a_sends.push_back({a_red, a_green, a_blue});
    if (a_send && a_prev_send) a_dbl <= a_dbl + 1;
    if (a_prev_pb && !a_px_busy) a_fall_cyc <= cyc;
    if (a_done) begin
      a_done_cnt <= a_done_cnt + 1;
      a_done_lat <= cyc - a_fall_cyc;
    end
    a_prev_send <= a_send;
    a_prev_pb   <= a_px_busy;
  end

  // ---------------- instance B ----------------
  logic        b_wr_en = 1'b0;
  logic [7:0]  b_wr_addr = 8'd0;
  logic [23:0] b_wr_data = 24'd0;
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_send, b_px_busy;
  logic [7:0]  b_red, b_green, b_blue;

  ws2812b_strip_ctrl #(.NUM_LEDS(1), .LATCH_CYCLES(4)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (b_wr_en),
    .i_wr_addr (b_wr_addr),
    .i_wr_data (b_wr_data),
    .i_start   (b_start),
    .o_busy    (b_busy),
    .o_done    (b_done),
    .o_send    (b_send),
    .o_red     (b_red),
    .o_green   (b_green),
    .o_blue    (b_blue),
    .i_px_busy (b_px_busy)
  );

  int b_ds_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_ds_cnt <= 0;
    else if (b_send) b_ds_cnt <= 6;
    else if (b_ds_cnt != 0) b_ds_cnt <= b_ds_cnt - 1;
  end
  assign b_px_busy = (b_ds_cnt != 0);

  logic [23:0] b_sends[$];
  int b_done_cnt = 0, b_fall_cyc = 0, b_done_lat = 0;
  logic b_prev_pb = 1'b0;
  always @(negedge clk) begin
    if (b_send) b_sends.push_back({b_red, b_green, b_blue});
    if (b_prev_pb && !b_px_busy) b_fall_cyc <= cyc;
    if (b_done) begin
      b_done_cnt <= b_done_cnt + 1;
      b_done_lat <= cyc - b_fall_cyc;
    end
    b_prev_pb <= b_px_busy;
  end

  // ---------------- helpers ----------------
  logic [23:0] exp_px [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [23:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_sends(input int n);
    int k = 0;
    while (a_sends.size() < n && k < 20000) begin @(negedge clk); k++; end
    check("a_send_wait_timeout", 32'(a_sends.size() >= n), 32'd1);
  endtask

  task automatic wait_a_pb(input logic v);
    int k = 0;
    while (a_px_busy !== v && k < 3000) begin @(negedge clk); k++; end
    check("a_px_busy_wait_timeout", 32'(a_px_busy), 32'(v));
  endtask

  task automatic wait_a_done();
    int k = 0;
    while (a_done !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
    check("a_done_wait_timeout", 32'(a_done), 32'd1);
  endtask

  task automatic check_frame_a(input string tag, input int base);
    check({tag, "_count"}, 32'(a_sends.size() - base), 32'd8);
    if (a_sends.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) check({tag, "_px"}, {8'h0, a_sends[base + i]}, {8'h0, exp_px[i]});
    end
  endtask

  initial begin
    int base, dbase, k;
    logic [23:0] old3;

    exp_px[0] = 24'hFF8040; exp_px[1] = 24'h4080FF; exp_px[2] = 24'h808080; exp_px[3] = 24'h010203;
    exp_px[4] = 24'h00FF00; exp_px[5] = 24'hA5A5A5; exp_px[6] = 24'h000001; exp_px[7] = 24'hFFFFFF;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_send", 32'(a_send), 32'd0);
    check("rst_rgb", {8'h0, a_red, a_green, a_blue}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Instance B: one pixel, 4 latch cycles; address 1 is out of range.
    b_wr_en = 1'b1; b_wr_addr = 8'd0; b_wr_data = 24'hC0FFEE; @(negedge clk);
    b_wr_addr = 8'd1; b_wr_data = 24'h111111; @(negedge clk);
    b_wr_en = 1'b0;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    k = 0;
    while (b_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check("b_done_wait_timeout", 32'(b_done), 32'd1);
    repeat (10) @(negedge clk);
    check("b_send_count", 32'(b_sends.size()), 32'd1);
    if (b_sends.size() >= 1) check("b_px0", {8'h0, b_sends[0]}, 32'h00C0FFEE);
    check("b_done_latency", 32'(b_done_lat), 32'd5);
    check("b_done_count", 32'(b_done_cnt), 32'd1);
    check("b_busy_after", 32'(b_busy), 32'd0);

    // Instance A buffer load, plus an out-of-range write that must be dropped.
    for (int i = 0; i < 8; i++) wr_a(8'(i), exp_px[i]);
    wr_a(8'd8, 24'h777777);
    check("a_idle_busy", 32'(a_busy), 32'd0);

    // Frame 1: full frame, with an extra start while busy.
    base = a_sends.size(); dbase = a_done_cnt;
    pulse_a_start();
    check("f1_busy_after_start", 32'(a_busy), 32'd1);
    wait_a_sends(base + 2);
    pulse_a_start();
    wait_a_done();
    repeat (20) @(negedge clk);
    check_frame_a("f1", base);
    check("f1_done_count", 32'(a_done_cnt - dbase), 32'd1);
    check("f1_done_latency", 32'(a_done_lat), 32'd3001);
    check("f1_busy_after", 32'(a_busy), 32'd0);
    check("f1_rgb_hold", {8'h0, a_red, a_green, a_blue}, {8'h0, exp_px[7]});
    check("f1_single_cycle_send", 32'(a_dbl), 32'd0);

    // Frame 2: mid-frame write to pixel 5, and a write to pixel 3 in the
    // very cycle pixel 3 is loaded (old data must be sent).
    base = a_sends.size(); dbase = a_done_cnt;
    pulse_a_start();
    wait_a_sends(base + 3);
    wr_a(8'd5, 24'h123456);
    exp_px[5] = 24'h123456;
    wait_a_pb(1'b1);
    wait_a_pb(1'b0);
    @(negedge clk);
    old3 = exp_px[3];
    wr_a(8'd3, 24'h0BADF0);
    exp_px[3] = 24'h0BADF0;
    wait_a_done();
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    repeat (20) @(negedge clk);
    check("f2_count", 32'(a_sends.size() - base), 32'd8);
    if (a_sends.size() >= base + 8) begin
      for (int i = 0; i < 8; i++)
        check("f2_px", {8'h0, a_sends[base + i]}, {8'h0, (i == 3) ? old3 : exp_px[i]});
    end
    check("f2_done_count", 32'(a_done_cnt - dbase), 32'd1);
    check("f2_start_in_done_ignored", 32'(a_busy), 32'd0);

    // Frame 3: reset during WAIT_DONE of pixel 3.
    base = a_sends.size();
    pulse_a_start();
    wait_a_sends(base + 4);
    wait_a_pb(1'b1);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_done", 32'(a_done), 32'd0);
    check("mid_rst_send", 32'(a_send), 32'd0);
    check("mid_rst_rgb", {8'h0, a_red, a_green, a_blue}, 32'd0);
    @(negedge clk);

    // Frame 4: start on the first edge after release, buffer intact.
    base = a_sends.size(); dbase = a_done_cnt;
    rst_n = 1'b1;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    check("f4_busy_first_edge", 32'(a_busy), 32'd1);
    wait_a_done();
    repeat (20) @(negedge clk);
    check_frame_a("f4", base);
    check("f4_done_count", 32'(a_done_cnt - dbase), 32'd1);
    check("f4_done_latency", 32'(a_done_lat), 32'd3001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
